// File: rtl/vcve2_vload_writeback.sv
// ---------------------------------------------------------------------------
// vcve2_vload_writeback
//
// Return path of the vector LSU interface. Load responses for one vector load
// are collected into a small FIFO and written one 32-bit word at a time into
// the VRF write port. The block also produces the request-side credit
// (req_allow_o) that throttles the LSU request issuer.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            begin a vector load (only honoured in IDLE)
//   vd_i               destination base register, captured with start_i
//   num_words_i        number of words in the load, captured with start_i
//   lsu_req_fire_i     issuer request accepted by the LSU this cycle
//   lsu_resp_valid_i   LSU response valid (no backpressure)
//   lsu_rdata_i        response data
//   lsu_err_i          response carries a bus error
//   req_allow_o        issuer may fire another request this cycle
//   vrf_we_o           VRF write request
//   vrf_waddr_o        VRF register index
//   vrf_word_o         word index inside the register
//   vrf_wdata_o        write data
//   vrf_wready_i       VRF accepts the write
//   busy_o             a load is in progress (state != IDLE)
//   done_o             one-cycle completion pulse
//   err_o              qualifies done_o: load ended by bus error or overflow
//
// Handshakes: a VRF write transfers on the rising edge where vrf_we_o and
// vrf_wready_i are both high; while vrf_we_o is high and vrf_wready_i is low,
// vrf_waddr_o / vrf_word_o / vrf_wdata_o hold their values. The LSU side has
// no backpressure: lsu_req_fire_i and lsu_resp_valid_i are single-cycle events.
//
// VLEN must be at least 64 so that the word index has at least one bit.
// ---------------------------------------------------------------------------
module vcve2_vload_writeback #(
    parameter int VLEN      = 128,
    parameter int DEPTH     = 4,
    parameter int MAX_WORDS = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [4:0]                      vd_i,
    input  logic [$clog2(MAX_WORDS):0]      num_words_i,
    input  logic                            lsu_req_fire_i,
    input  logic                            lsu_resp_valid_i,
    input  logic [31:0]                     lsu_rdata_i,
    input  logic                            lsu_err_i,
    output logic                            req_allow_o,
    output logic                            vrf_we_o,
    output logic [4:0]                      vrf_waddr_o,
    output logic [$clog2(VLEN/32)-1:0]      vrf_word_o,
    output logic [31:0]                     vrf_wdata_o,
    input  logic                            vrf_wready_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int WPR = VLEN / 32;
    localparam int WB  = $clog2(WPR);
    localparam int CW  = $clog2(MAX_WORDS) + 1;
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;

    logic [4:0]     vd_q;
    logic [CW-1:0]  num_q;
    logic [CW-1:0]  issued_q;
    logic [CW-1:0]  written_q;
    logic [CW-1:0]  inflight_q;
    logic           err_q;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;

    logic           active;
    logic           start_ok;
    logic           fifo_empty, fifo_full;
    logic           pop, push_try, push, overflow, error_now;
    logic [CW:0]    occupancy;

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    always_comb begin
        active     = (state_q == S_ACTIVE);
        start_ok   = (state_q == S_IDLE) && start_i;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == (AW+1)'(DEPTH));
        vrf_we_o   = active && !fifo_empty;
        pop        = vrf_we_o && vrf_wready_i;
        push_try   = active && lsu_resp_valid_i && !lsu_err_i;
        // A pop in the same cycle frees the slot, so full alone is not overflow.
        overflow   = push_try && fifo_full && !pop;
        push       = push_try && !overflow;
        error_now  = (active && lsu_resp_valid_i && lsu_err_i) || overflow;
        // Credit counts both buffered words and words still owed by the LSU,
        // so every issued request is guaranteed a FIFO slot.
        occupancy  = (CW+1)'(count_q) + (CW+1)'(inflight_q);
        req_allow_o = active && (occupancy < (CW+1)'(DEPTH)) && (issued_q < num_q);
    end

    // Output fields are forced to zero when no write is requested so the port
    // reads all-zero out of reset even though FIFO storage is not reset.
    always_comb begin
        vrf_waddr_o = '0;
        vrf_word_o  = '0;
        vrf_wdata_o = '0;
        if (vrf_we_o) begin
            vrf_waddr_o = vd_q + 5'(written_q >> WB);
            vrf_word_o  = written_q[WB-1:0];
            vrf_wdata_o = mem[rd_ptr_q];
        end
    end

    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
        err_o  = (state_q == S_DONE) && err_q;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = (num_words_i == '0) ? S_DONE : S_ACTIVE;
            end
            S_ACTIVE: begin
                if (error_now)              state_d = S_FLUSH;
                else if (written_q == num_q) state_d = S_DONE;
            end
            S_FLUSH: begin
                if (inflight_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load context and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vd_q       <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else if (start_ok) begin
            vd_q       <= vd_i;
            num_q      <= num_words_i;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (active && lsu_req_fire_i) issued_q <= issued_q + 1'b1;
            if (pop)                      written_q <= written_q + 1'b1;
            if (error_now)                err_q <= 1'b1;
            if (active || state_q == S_FLUSH) begin
                if (lsu_req_fire_i && !lsu_resp_valid_i)
                    inflight_q <= inflight_q + 1'b1;
                else if (!lsu_req_fire_i && lsu_resp_valid_i && inflight_q != '0)
                    inflight_q <= inflight_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO. An error empties it in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok || error_now) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= lsu_rdata_i;
    end

endmodule

// File: tb/tb_vcve2_vload_writeback.sv
// Bench for vcve2_vload_writeback: directed scenarios plus randomized loads.
// A behavioural issuer/LSU model produces requests and responses; every good
// response defines the next expected VRF write (register, word, data).
module tb_vcve2_vload_writeback;

  localparam int VLEN      = 128;
  localparam int DEPTH     = 4;
  localparam int MAX_WORDS = 32;
  localparam int WPR       = VLEN / 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        start_i;
  logic [4:0]  vd_i;
  logic [5:0]  num_words_i;
  logic        lsu_req_fire_i;
  logic        lsu_resp_valid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_err_i;
  logic        req_allow_o;
  logic        vrf_we_o;
  logic [4:0]  vrf_waddr_o;
  logic [1:0]  vrf_word_o;
  logic [31:0] vrf_wdata_o;
  logic        vrf_wready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  vcve2_vload_writeback #(
    .VLEN(VLEN), .DEPTH(DEPTH), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .vd_i(vd_i),
    .num_words_i(num_words_i), .lsu_req_fire_i(lsu_req_fire_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_rdata_i(lsu_rdata_i),
    .lsu_err_i(lsu_err_i), .req_allow_o(req_allow_o), .vrf_we_o(vrf_we_o),
    .vrf_waddr_o(vrf_waddr_o), .vrf_word_o(vrf_word_o),
    .vrf_wdata_o(vrf_wdata_o), .vrf_wready_i(vrf_wready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [38:0] exp_q[$];
  logic [31:0] lsu_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    start_i = 0; vd_i = 0; num_words_i = 0;
    lsu_req_fire_i = 0; lsu_resp_valid_i = 0; lsu_rdata_i = 0;
    lsu_err_i = 0; vrf_wready_i = 0;
  endtask

  // One vector load driven by the issuer/LSU model.
  //   err_at  : index of the response carrying a bus error (-1: none)
  //   ovf     : issuer ignores req_allow_o and the VRF never accepts
  //   hold    : initial cycles with vrf_wready_i forced low
  //   dbase   : nonzero -> response data dbase+i, else random
  task automatic run_load(input logic [4:0] vd, input int num, input int err_at,
                          input bit ovf, input int wr_pct, input int fire_pct,
                          input int hold, input logic [31:0] dbase);
    int fired = 0;
    int resp_n = 0;
    int good = 0;
    int writes = 0;
    int cyc = 0;
    bit erred = 0;
    bit seen_done = 0;
    logic done_err = 0;
    logic [31:0] d;
    exp_q.delete();
    lsu_q.delete();
    start_i = 1; vd_i = vd; num_words_i = 6'(num);
    @(negedge clk);
    start_i = 0;
    while (cyc < 3000) begin
      lsu_req_fire_i = 0; lsu_resp_valid_i = 0; lsu_err_i = 0; vrf_wready_i = 0;
      if (done_o) begin
        seen_done = 1;
        done_err = err_o;
        break;
      end
      if (!ovf && !erred) check("outstanding_le_depth", 64'(fired - writes <= DEPTH), 1);
      if (hold > 0 && cyc == hold) begin
        check("allow_drop_when_full", 64'(req_allow_o), 0);
        check("outstanding_at_hold", 64'(fired), DEPTH);
      end
      // VRF side
      if (!ovf && cyc >= hold) vrf_wready_i = ($urandom_range(0, 99) < wr_pct);
      if (vrf_we_o && vrf_wready_i) begin
        if (exp_q.size() == 0) check("write_unexpected", 1, 0);
        else check("write", 64'({vrf_waddr_o, vrf_word_o, vrf_wdata_o}), 64'(exp_q.pop_front()));
        writes++;
      end
      // LSU response side (at least one cycle after the request)
      if (lsu_q.size() > 0 && (ovf || $urandom_range(0, 1) == 1)) begin
        lsu_resp_valid_i = 1;
        lsu_rdata_i = lsu_q.pop_front();
        if (resp_n == err_at) begin
          lsu_err_i = 1;
          erred = 1;
        end else if (!erred) begin
          exp_q.push_back({5'((vd + good / WPR) % 32), 2'(good % WPR), lsu_rdata_i});
          good++;
        end
        resp_n++;
      end
      // issuer side
      if (!ovf && req_allow_o) check("allow_only_below_num", 64'(fired < num), 1);
      if (fired < num && (ovf || (req_allow_o && $urandom_range(0, 99) < fire_pct))) begin
        lsu_req_fire_i = 1;
        d = (dbase != 0) ? dbase + 32'(fired) : $urandom();
        lsu_q.push_back(d);
        fired++;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(seen_done), 1);
    if (seen_done) begin
      check("err_with_done", 64'(done_err), (err_at >= 0 || ovf) ? 1 : 0);
      if (ovf)                 check("writes_overflow", 64'(writes), 0);
      else if (err_at < 0)     check("writes_total", 64'(writes), 64'(num));
      else if (wr_pct == 100)  check("writes_before_err", 64'(writes), 64'(err_at));
      else                     check("writes_le_err", 64'(writes <= err_at), 1);
      check("inflight_drained", 64'(lsu_q.size()), 0);
    end
    clear_inputs();
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 0);
    check("idle_after_done", 64'(busy_o), 0);
  endtask

  initial begin
    clear_inputs();
    rst_i = 1;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_busy", 64'(busy_o), 0);
    check("rst_we", 64'(vrf_we_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_err", 64'(err_o), 0);
    check("rst_allow", 64'(req_allow_o), 0);
    check("rst_outputs", 64'({vrf_waddr_o, vrf_word_o, vrf_wdata_o}), 0);
    rst_i = 0;
    @(negedge clk);

    // basic load: regs 3 and 4, data A0..A7
    run_load(5'd3, 8, -1, 0, 100, 100, 0, 32'hA0);
    // VRF stalls 10 cycles; credit must stop at DEPTH outstanding
    run_load(5'd9, 8, -1, 0, 100, 100, 10, 32'h0);
    // bus error on the third response
    run_load(5'd5, 4, 2, 0, 100, 100, 0, 32'h300);
    // overflow: issuer ignores credit, VRF never ready
    run_load(5'd12, 8, -1, 1, 0, 100, 0, 32'h400);
    // register index wraps 30, 31, 0
    run_load(5'd30, 12, -1, 0, 100, 100, 0, 32'h100);
    // full-length load
    run_load(5'd17, MAX_WORDS, -1, 0, 60, 80, 0, 32'h0);

    // randomized loads
    for (int i = 0; i < 15; i++) begin
      int n;
      int e;
      n = $urandom_range(1, MAX_WORDS);
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_load(5'($urandom_range(0, 31)), n, e, 0, $urandom_range(20, 100),
               $urandom_range(30, 100), 0, 32'h0);
    end

    // reset in the middle of a load with a word buffered
    start_i = 1; vd_i = 5'd7; num_words_i = 6'd8;
    @(negedge clk);
    start_i = 0; lsu_req_fire_i = 1;
    @(negedge clk);
    lsu_req_fire_i = 0; lsu_resp_valid_i = 1; lsu_rdata_i = 32'h55;
    @(negedge clk);
    lsu_resp_valid_i = 0;
    check("pre_rst_we", 64'(vrf_we_o), 1);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    check("midrst_we", 64'(vrf_we_o), 0);
    check("midrst_busy", 64'(busy_o), 0);
    check("midrst_allow", 64'(req_allow_o), 0);
    // zero-length load completes immediately
    start_i = 1; vd_i = 5'd1; num_words_i = 6'd0;
    @(negedge clk);
    start_i = 0;
    check("zero_len_done", 64'(done_o), 1);
    check("zero_len_err", 64'(err_o), 0);
    @(negedge clk);
    check("zero_len_done_pulse", 64'(done_o), 0);

    // response while idle is ignored
    lsu_resp_valid_i = 1; lsu_rdata_i = 32'hDEAD;
    @(negedge clk);
    lsu_resp_valid_i = 0;
    @(negedge clk);
    check("idle_resp_we", 64'(vrf_we_o), 0);
    check("idle_resp_busy", 64'(busy_o), 0);

    // a normal load still works afterwards
    run_load(5'd0, 5, -1, 0, 100, 100, 0, 32'h700);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
